// File: rtl/capture_bank_if.sv
// capture_bank_if: groups the capture/commit signals of capture_bank.
//   master : control side; drives enables, data and commit requests
//   slave  : capture_bank itself; drives live/shadow banks and status
// Signals:
//   i_en[NUM_CH]        per-channel capture enable
//   i_bcast             enabled channels take channel 0's slice of i_a
//   i_a[NUM_CH*WIDTH]   channel data, channel k at [k*WIDTH +: WIDTH]
//   i_commit_req        start copying the live bank into the shadow bank
//   o_commit_ack        one-cycle pulse when a commit completes
//   o_busy              commit engine active
//   o_a / o_b           live bank / committed shadow bank
//   o_dirty / o_ovf     captured since last copy / sticky lost-value flag
interface capture_bank_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 8
);
  logic [NUM_CH-1:0]       i_en;
  logic                    i_bcast;
  logic [NUM_CH*WIDTH-1:0] i_a;
  logic                    i_commit_req;
  logic                    o_commit_ack;
  logic                    o_busy;
  logic [NUM_CH*WIDTH-1:0] o_a;
  logic [NUM_CH*WIDTH-1:0] o_b;
  logic [NUM_CH-1:0]       o_dirty;
  logic [NUM_CH-1:0]       o_ovf;

  modport master (
    output i_en, i_bcast, i_a, i_commit_req,
    input  o_commit_ack, o_busy, o_a, o_b, o_dirty, o_ovf
  );

  modport slave (
    input  i_en, i_bcast, i_a, i_commit_req,
    output o_commit_ack, o_busy, o_a, o_b, o_dirty, o_ovf
  );
endinterface

// File: rtl/capture_bank.sv
// capture_bank: NUM_CH x WIDTH live register bank with per-channel enables
// and broadcast, plus a shadow bank filled one channel per cycle by a
// req/ack commit engine.
// Ports:
//   i_clk   clock, all state on rising edge
//   i_srst  synchronous active-high reset, highest priority
//   bus     capture_bank_if.slave (capture inputs, commit handshake, banks)
//
// state | meaning
// IDLE  | waiting for i_commit_req
// COPY  | copying live[ptr] into shadow[ptr], one channel per edge
// ACK   | o_commit_ack high for this single cycle
module capture_bank #(
  parameter int               WIDTH       = 8,
  parameter int               NUM_CH      = 8,
  parameter bit               TRANSPARENT = 1'b0,
  parameter logic [WIDTH-1:0] RST_VAL     = '0
) (
  input logic           i_clk,
  input logic           i_srst,
  capture_bank_if.slave bus
);
  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, COPY, ACK} state_t;

  state_t           state;
  logic [PTR_W-1:0] ptr;
  logic             ack;
  logic             busy;
  logic [WIDTH-1:0] live   [NUM_CH];
  logic [WIDTH-1:0] shadow [NUM_CH];
  logic [WIDTH-1:0] sel    [NUM_CH];
  logic [NUM_CH-1:0] dirty;
  logic [NUM_CH-1:0] ovf;

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      sel[k] = bus.i_bcast ? bus.i_a[0 +: WIDTH] : bus.i_a[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      state <= IDLE;
      ptr   <= '0;
      ack   <= 1'b0;
      busy  <= 1'b0;
      dirty <= '0;
      ovf   <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        live[k]   <= RST_VAL;
        shadow[k] <= RST_VAL;
      end
    end else begin
      ack <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_commit_req) begin
            state <= COPY;
            ptr   <= '0;
            busy  <= 1'b1;
          end
        end
        COPY: begin
          ptr <= ptr + PTR_W'(1);
          if (ptr == PTR_W'(NUM_CH - 1)) begin
            state <= ACK;
            ack   <= 1'b1;
          end
        end
        ACK: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      for (int k = 0; k < NUM_CH; k++) begin
        if (bus.i_en[k]) live[k] <= sel[k];
        if (state == COPY && ptr == PTR_W'(k)) begin
          // shadow takes the pre-edge live value; a same-edge capture
          // leaves the channel dirty for the next commit
          shadow[k] <= live[k];
          dirty[k]  <= bus.i_en[k];
          ovf[k]    <= 1'b0;
        end else if (bus.i_en[k]) begin
          dirty[k] <= 1'b1;
          if (dirty[k]) ovf[k] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.o_a = '0;
    bus.o_b = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (TRANSPARENT && bus.i_en[k]) bus.o_a[k*WIDTH +: WIDTH] = sel[k];
      else                            bus.o_a[k*WIDTH +: WIDTH] = live[k];
      bus.o_b[k*WIDTH +: WIDTH] = shadow[k];
    end
  end

  assign bus.o_dirty      = dirty;
  assign bus.o_ovf        = ovf;
  assign bus.o_commit_ack = ack;
  assign bus.o_busy       = busy;
endmodule

// File: tb/tb_capture_bank.sv
module tb_capture_bank;
  logic clk = 1'b0;
  logic srst;
  int total = 0;
  int bad   = 0;
  int acks;
  logic [63:0] live_snap;
  logic [63:0] mask;

  always #5 clk = ~clk;

  capture_bank_if #(.WIDTH(8), .NUM_CH(8)) bus0 ();
  capture_bank_if #(.WIDTH(8), .NUM_CH(8)) bus1 ();

  capture_bank #(.WIDTH(8), .NUM_CH(8), .TRANSPARENT(1'b0), .RST_VAL(8'h00))
    u_reg (.i_clk(clk), .i_srst(srst), .bus(bus0));
  capture_bank #(.WIDTH(8), .NUM_CH(8), .TRANSPARENT(1'b1), .RST_VAL(8'h00))
    u_trn (.i_clk(clk), .i_srst(srst), .bus(bus1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    srst = 1'b1;
    bus0.i_en = '0; bus0.i_bcast = 1'b0; bus0.i_a = '0; bus0.i_commit_req = 1'b0;
    bus1.i_en = '0; bus1.i_bcast = 1'b0; bus1.i_a = '0; bus1.i_commit_req = 1'b0;
    tick(); tick();
    srst = 1'b0;

    // reset state
    chk("rst_o_a",   bus0.o_a, 64'h0);
    chk("rst_o_b",   bus0.o_b, 64'h0);
    chk("rst_dirty", {56'h0, bus0.o_dirty}, 64'h0);
    chk("rst_ovf",   {56'h0, bus0.o_ovf}, 64'h0);
    chk("rst_busy",  {63'h0, bus0.o_busy}, 64'h0);
    chk("rst_ack",   {63'h0, bus0.o_commit_ack}, 64'h0);

    // per-channel capture
    bus0.i_en = 8'h05; bus0.i_a = 64'hFFFF_FFFF_FF3C_EEA5;
    tick();
    bus0.i_en = '0; bus0.i_a = '0;
    chk("cap_o_a",   bus0.o_a, 64'h0000_0000_003C_00A5);
    chk("cap_dirty", {56'h0, bus0.o_dirty}, 64'h05);
    chk("cap_o_b",   bus0.o_b, 64'h0);
    chk("cap_ovf",   {56'h0, bus0.o_ovf}, 64'h0);

    // broadcast of channel 0 into channels 4..7
    bus0.i_en = 8'hF0; bus0.i_bcast = 1'b1; bus0.i_a = 64'hDEAD_BEEF_CAFE_0077;
    tick();
    bus0.i_en = '0; bus0.i_bcast = 1'b0; bus0.i_a = '0;
    chk("bc_o_a",   bus0.o_a, 64'h7777_7777_003C_00A5);
    chk("bc_dirty", {56'h0, bus0.o_dirty}, 64'hF5);

    // full commit, channel k copied at E(k+1), ack after E8
    live_snap = 64'h7777_7777_003C_00A5;
    bus0.i_commit_req = 1'b1;
    tick();
    bus0.i_commit_req = 1'b0;
    chk("cm_busy0", {63'h0, bus0.o_busy}, 64'h1);
    chk("cm_o_b0",  bus0.o_b, 64'h0);
    for (int k = 0; k < 8; k++) begin
      tick();
      mask = (k == 7) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'h1 << ((k + 1) * 8)) - 64'h1);
      chk($sformatf("cm_o_b_ch%0d", k), bus0.o_b, live_snap & mask);
      chk($sformatf("cm_busy_ch%0d", k), {63'h0, bus0.o_busy}, 64'h1);
      chk($sformatf("cm_ack_ch%0d", k), {63'h0, bus0.o_commit_ack}, (k == 7) ? 64'h1 : 64'h0);
    end
    tick();
    chk("cm_ack_end",  {63'h0, bus0.o_commit_ack}, 64'h0);
    chk("cm_busy_end", {63'h0, bus0.o_busy}, 64'h0);
    chk("cm_dirty",    {56'h0, bus0.o_dirty}, 64'h0);
    chk("cm_ovf",      {56'h0, bus0.o_ovf}, 64'h0);

    // overwrite without commit sets ovf
    bus0.i_en = 8'h08; bus0.i_a = 64'h0000_0000_1100_0000;
    tick();
    bus0.i_a = 64'h0000_0000_2200_0000;
    tick();
    bus0.i_en = '0; bus0.i_a = '0;
    chk("ov_ovf",   {56'h0, bus0.o_ovf}, 64'h08);
    chk("ov_dirty", {56'h0, bus0.o_dirty}, 64'h08);
    chk("ov_o_a",   bus0.o_a, 64'h7777_7777_223C_00A5);

    // capture on ch3's own copy edge (E4)
    bus0.i_commit_req = 1'b1;
    tick();
    bus0.i_commit_req = 1'b0;
    tick(); tick(); tick();
    bus0.i_en = 8'h08; bus0.i_a = 64'h0000_0000_3300_0000;
    tick();
    bus0.i_en = '0; bus0.i_a = '0;
    chk("cc_o_b",   bus0.o_b, 64'h7777_7777_223C_00A5);
    chk("cc_dirty", {56'h0, bus0.o_dirty}, 64'h08);
    chk("cc_ovf",   {56'h0, bus0.o_ovf}, 64'h00);
    chk("cc_o_a",   bus0.o_a, 64'h7777_7777_333C_00A5);
    tick(); tick(); tick(); tick();
    chk("cc_ack", {63'h0, bus0.o_commit_ack}, 64'h1);
    tick();
    chk("cc_dirty_end", {56'h0, bus0.o_dirty}, 64'h08);

    // reset during COPY aborts without ack
    bus0.i_commit_req = 1'b1;
    tick();
    bus0.i_commit_req = 1'b0;
    tick(); tick(); tick();
    srst = 1'b1;
    tick();
    srst = 1'b0;
    chk("ra_o_a",  bus0.o_a, 64'h0);
    chk("ra_o_b",  bus0.o_b, 64'h0);
    chk("ra_dirty", {56'h0, bus0.o_dirty}, 64'h0);
    chk("ra_busy", {63'h0, bus0.o_busy}, 64'h0);
    chk("ra_ack",  {63'h0, bus0.o_commit_ack}, 64'h0);
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus0.o_commit_ack) acks++;
    end
    chk("ra_no_ack", 64'(acks), 64'h0);

    // second req while busy is dropped
    bus0.i_en = 8'h01; bus0.i_a = 64'h0000_0000_0000_0042;
    tick();
    bus0.i_en = '0; bus0.i_a = '0;
    acks = 0;
    bus0.i_commit_req = 1'b1;
    tick();
    bus0.i_commit_req = 1'b0;
    if (bus0.o_commit_ack) acks++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus0.o_commit_ack) acks++;
    end
    bus0.i_commit_req = 1'b1;
    tick();
    bus0.i_commit_req = 1'b0;
    if (bus0.o_commit_ack) acks++;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus0.o_commit_ack) acks++;
    end
    chk("busy_req_acks", 64'(acks), 64'h1);
    chk("busy_req_o_b",  bus0.o_b, 64'h0000_0000_0000_0042);

    // held req restarts each commit: acks after ticks 9 and 19
    acks = 0;
    bus0.i_commit_req = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (bus0.o_commit_ack) acks++;
    end
    bus0.i_commit_req = 1'b0;
    chk("held_req_acks", 64'(acks), 64'h2);
    for (int i = 0; i < 12; i++) tick();
    chk("held_req_idle", {63'h0, bus0.o_busy}, 64'h0);

    // transparent instance: zero latency, then hold
    bus1.i_en = 8'h02; bus1.i_a = 64'h0000_0000_0000_5A00;
    #1;
    chk("tr_same_cycle", bus1.o_a, 64'h0000_0000_0000_5A00);
    tick();
    bus1.i_en = '0; bus1.i_a = 64'h0000_0000_0000_9900;
    #1;
    chk("tr_hold", bus1.o_a, 64'h0000_0000_0000_5A00);
    chk("tr_dirty", {56'h0, bus1.o_dirty}, 64'h02);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
